sb_wrr_arb: RTL and testbench
=============================

Name: sb_wrr_arb

Overview:
- Grant controller for the two-master shared system bus: instruction fetch (M0) and load/store (M1) contending for the single slave-side path ahead of the pipeline stage and 1-to-4 address decoder.
- Decides which master owns the path, holds ownership until the transaction's response handshake completes, and shares bandwidth by weighted round-robin.
- Optionally aborts hung transactions with a timeout.
- Outputs drive the master/slave channel mux select; the block carries no data.

Parameters:
- W0, 2, consecutive contended grants allowed to M0 before yielding (1..15)
- W1, 1, consecutive contended grants allowed to M1 (1..15)
- TIMEOUT, 256, cycles a granted transaction may stay in ADDR+RESP before abort (2..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sb_arvalid_m0  in  1  M0 read request
- sb_wvalid_m0  in  1  M0 write request
- sb_arvalid_m1  in  1  M1 read request
- sb_wvalid_m1  in  1  M1 write request
- sb_arready_s  in  1  slave-side read address accept
- sb_wready_s  in  1  slave-side write accept
- sb_rvalid_s  in  1  slave-side read data valid
- sb_rready_s  in  1  muxed master read data ready
- sb_bvalid_s  in  1  slave-side write response valid
- sb_bready_s  in  1  muxed master write response ready
- gnt_m0  out  1  M0 owns path
- gnt_m1  out  1  M1 owns path
- gnt_wr  out  1  owned transaction is a write (0 = read)
- busy  out  1  state != IDLE
- abort  out  1  one-cycle pulse: transaction timed out; mux must return bresp=1 / rdata=0 to owner
- err_cnt  out  8  saturating abort count

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - gnt_m0 = gnt_m1 = gnt_wr = busy = abort = 0, err_cnt = 0, state = IDLE.
  - Internal: last_owner = M1, credit = W1. This makes the first contended grant go to M0.
- Request per master: req_mX = arvalid_mX | wvalid_mX.
  - If both arvalid and wvalid are set, the read is chosen first (gnt_wr = 0).
- IDLE:
  - No request: stay.
  - Exactly one master requesting: grant it.
  - Both requesting: grant last_owner if credit < W(last_owner), else the other master.
  - Grant and gnt_wr are registered, so there is 1 cycle from request to gnt. Go to ADDR.
- Credit update on every grant:
  - Same master as last_owner: credit = min(credit+1, 15).
  - Different master: last_owner = new owner, credit = 1.
- ADDR:
  - Read: on arvalid&arready (owner's valid, slave ready), go to RESP.
  - Write: on wvalid&wready, go to RESP.
- RESP:
  - Read: on rvalid_s & rready_s, go to IDLE.
  - Write: on bvalid_s & bready_s, go to IDLE.
  - Grants drop the cycle after the completing handshake.
- Address handshake and response completing in the same cycle is not possible (the pipeline adds ≥1 cycle). A response seen in ADDR is ignored.
- Owner's valid deasserting in ADDR is a protocol violation: grant is held, and the transaction can only end through timeout.
- No re-arbitration occurs while busy. The non-owner's requests wait.
- Both gnt outputs are never high together. gnt_wr is meaningful only while a gnt is high and is 0 otherwise.
- Reset asserted mid-transaction: immediate return to reset values; the slave's in-flight response is ignored.

Optional Feature:
- Macro SB_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on entry to ADDR, incremented each cycle in ADDR/RESP.
  - When counter == TIMEOUT-1 and no completion this cycle: abort = 1 for one cycle, state → IDLE, grants drop next cycle, err_cnt += 1 (saturates at 255).
  - Completion on the same cycle as expiry wins; no abort.
- Not defined: no counter, abort tied 0, err_cnt tied 0, transactions may hang indefinitely.

Decomposition:
- Shared package sb_pkg holds:
  - state encoding (IDLE=2'd0, ADDR=2'd1, RESP=2'd2)
  - master index constants M0=1'b0, M1=1'b1
  - response code SB_RESP_ERR=1'b1
- One sub-module, sb_wrr_pick: combinational weighted pick. Inputs req_m0, req_m1, last_owner, credit, W0, W1; output winner and valid.
- FSM, credit registers and timeout live in sb_wrr_arb.

Test Plan:
- M0 read alone: arvalid_m0=1 at t0 → gnt_m0=1, gnt_wr=0 at t1; arready at t2; rvalid&rready at t4 → gnt_m0=0 at t5; busy=0.
- Both masters request continuously, single-cycle transactions, W0=2/W1=1 → grant sequence M0,M0,M1,M0,M0,M1.
- M1 arvalid and wvalid simultaneously → read granted first (gnt_wr=0); after completion the write is granted (gnt_wr=1).
- M1 write granted while M0 requests mid-transaction → M0 not granted until the cycle after bvalid&bready; gnt_m0 and gnt_m1 never overlap.
- With SB_ARB_TIMEOUT_EN and TIMEOUT=8, M0 read with no rvalid → abort pulses exactly 8 cycles after ADDR entry, err_cnt=1, busy=0 next cycle; 300 repeats → err_cnt=255.
- Assert rst in RESP → outputs at reset values within the same cycle (async); after release, contended request grants M0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared definitions for the two-master system-bus grant controller:
// FSM state encoding, master indices and the abort response code.
package sb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic SB_RESP_ERR = 1'b1;

    localparam logic [3:0] CREDIT_MAX = 4'd15;

    function automatic logic [3:0] credit_next(input logic [3:0] credit);
        return (credit == CREDIT_MAX) ? credit : credit + 4'd1;
    endfunction

endpackage

// File: rtl/sb_wrr_pick.sv
// Combinational weighted round-robin pick between M0 and M1: the previous
// owner keeps the path under contention only while it still has credit.
module sb_wrr_pick
    import sb_pkg::*;
(
    input  logic       req_m0,
    input  logic       req_m1,
    input  logic       last_owner,
    input  logic [3:0] credit,
    input  logic [3:0] w0,
    input  logic [3:0] w1,
    output logic       winner,
    output logic       valid
);

    logic [3:0] w_last;

    always_comb begin
        w_last = (last_owner == M0) ? w0 : w1;
        valid  = req_m0 | req_m1;
        if (req_m0 && req_m1) begin
            winner = (credit < w_last) ? last_owner : ~last_owner;
        end else begin
            winner = req_m1 ? M1 : M0;
        end
    end

endmodule

// File: rtl/sb_wrr_arb.sv
// Grant controller for the shared system-bus slave path (M0 fetch, M1 load/store).
// Optional hung-transaction abort is enabled by defining SB_ARB_TIMEOUT_EN.
module sb_wrr_arb
    import sb_pkg::*;
#(
    parameter int unsigned W0      = 2,
    parameter int unsigned W1      = 1,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sb_arvalid_m0,
    input  logic       sb_wvalid_m0,
    input  logic       sb_arvalid_m1,
    input  logic       sb_wvalid_m1,
    input  logic       sb_arready_s,
    input  logic       sb_wready_s,
    input  logic       sb_rvalid_s,
    input  logic       sb_rready_s,
    input  logic       sb_bvalid_s,
    input  logic       sb_bready_s,
    output logic       gnt_m0,
    output logic       gnt_m1,
    output logic       gnt_wr,
    output logic       busy,
    output logic       abort,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] W0_L = 4'(W0);
    localparam logic [3:0] W1_L = 4'(W1);

    logic [1:0] state;
    logic       owner;
    logic       is_wr;
    logic       last_owner;
    logic [3:0] credit;
    logic       req_m0;
    logic       req_m1;
    logic       winner;
    logic       win_valid;
    logic       own_arvalid;
    logic       own_wvalid;
    logic       addr_hs;
    logic       resp_hs;
    logic       timeout_hit;

    assign req_m0 = sb_arvalid_m0 | sb_wvalid_m0;
    assign req_m1 = sb_arvalid_m1 | sb_wvalid_m1;

    sb_wrr_pick u_pick (
        .req_m0     (req_m0),
        .req_m1     (req_m1),
        .last_owner (last_owner),
        .credit     (credit),
        .w0         (W0_L),
        .w1         (W1_L),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_comb begin
        own_arvalid = (owner == M0) ? sb_arvalid_m0 : sb_arvalid_m1;
        own_wvalid  = (owner == M0) ? sb_wvalid_m0  : sb_wvalid_m1;
        addr_hs = (state == ADDR) &&
                  (is_wr ? (own_wvalid & sb_wready_s) : (own_arvalid & sb_arready_s));
        resp_hs = (state == RESP) &&
                  (is_wr ? (sb_bvalid_s & sb_bready_s) : (sb_rvalid_s & sb_rready_s));
    end

`ifdef SB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // A response completing on the expiry cycle takes priority over the abort.
    assign timeout_hit = (state != IDLE) && (tmo_cnt == 16'(TIMEOUT - 1)) && !resp_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_cnt <= '0;
        end else begin
            tmo_cnt <= (state == IDLE) ? '0 : tmo_cnt + 16'd1;
            if (timeout_hit && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |16'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign err_cnt        = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= M0;
            is_wr      <= 1'b0;
            last_owner <= M1;
            credit     <= W1_L;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state <= ADDR;
                        owner <= winner;
                        is_wr <= (winner == M0) ? ~sb_arvalid_m0 : ~sb_arvalid_m1;
                        if (winner == last_owner) begin
                            credit <= credit_next(credit);
                        end else begin
                            last_owner <= winner;
                            credit     <= 4'd1;
                        end
                    end
                end
                ADDR: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (addr_hs) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_hs || timeout_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign gnt_m0 = busy && (owner == M0);
    assign gnt_m1 = busy && (owner == M1);
    assign gnt_wr = busy && is_wr;
    assign abort  = timeout_hit;

endmodule

// File: tb/tb_sb_wrr_arb.sv
// Bench for sb_wrr_arb: directed scenarios plus random traffic checked each
// cycle against a transaction-level reference model of the arbiter.
module tb_sb_wrr_arb;

`ifdef SB_ARB_TIMEOUT_EN
    localparam int unsigned TMO    = 8;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam int unsigned TMO    = 256;
    localparam bit          TMO_EN = 1'b0;
`endif
    localparam int unsigned W0 = 2;
    localparam int unsigned W1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ar0 = 1'b0, wv0 = 1'b0, ar1 = 1'b0, wv1 = 1'b0;
    logic       arready = 1'b0, wready = 1'b0;
    logic       rvalid = 1'b0, rready = 1'b0, bvalid = 1'b0, bready = 1'b0;
    logic       gnt_m0, gnt_m1, gnt_wr, busy, abort;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: transaction view of the bus owner.
    bit m_busy;
    int m_owner;
    bit m_wr;
    int m_phase;   // 0: waiting for address handshake, 1: waiting for response
    int m_age;     // cycles spent in the current transaction
    int m_last;
    int m_streak;  // consecutive grants held by m_last
    int m_err;

    sb_wrr_arb #(
        .W0      (W0),
        .W1      (W1),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sb_arvalid_m0 (ar0),
        .sb_wvalid_m0  (wv0),
        .sb_arvalid_m1 (ar1),
        .sb_wvalid_m1  (wv1),
        .sb_arready_s  (arready),
        .sb_wready_s   (wready),
        .sb_rvalid_s   (rvalid),
        .sb_rready_s   (rready),
        .sb_bvalid_s   (bvalid),
        .sb_bready_s   (bready),
        .gnt_m0        (gnt_m0),
        .gnt_m1        (gnt_m1),
        .gnt_wr        (gnt_wr),
        .busy          (busy),
        .abort         (abort),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_arv(input int m);
        return (m == 1) ? ar1 : ar0;
    endfunction

    function automatic bit m_wv(input int m);
        return (m == 1) ? wv1 : wv0;
    endfunction

    function automatic bit m_done();
        return m_busy && m_phase == 1 && (m_wr ? (bvalid && bready) : (rvalid && rready));
    endfunction

    function automatic bit m_abort();
        return TMO_EN && m_busy && m_age == int'(TMO) - 1 && !m_done();
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_wr = 0; m_phase = 0; m_age = 0;
        m_last = 1; m_streak = int'(W1); m_err = 0;
    endtask

    task automatic model_advance();
        int w;
        bit r0, r1;
        r0 = ar0 | wv0;
        r1 = ar1 | wv1;
        if (!m_busy) begin
            if (r0 || r1) begin
                if (r0 && r1)
                    w = (m_streak < int'((m_last == 1) ? W1 : W0)) ? m_last : 1 - m_last;
                else
                    w = r1 ? 1 : 0;
                if (w == m_last) m_streak++;
                else begin
                    m_last = w;
                    m_streak = 1;
                end
                m_owner = w; m_wr = !m_arv(w); m_busy = 1; m_phase = 0; m_age = 0;
            end
        end else if (m_abort()) begin
            m_busy = 0;
            if (m_err < 255) m_err++;
        end else if (m_phase == 0) begin
            if (m_wr ? (m_wv(m_owner) && wready) : (m_arv(m_owner) && arready)) m_phase = 1;
            m_age++;
        end else if (m_done()) begin
            m_busy = 0;
        end else begin
            m_age++;
        end
    endtask

    // Inputs are already applied for this cycle; compare, then clock the model.
    task automatic step(input string tag);
        logic [12:0] exp_v, obs_v;
        @(negedge clk);
        exp_v = {m_busy && m_owner == 0, m_busy && m_owner == 1, m_busy && m_wr,
                 m_busy, m_abort(), 8'(m_err)};
        obs_v = {gnt_m0, gnt_m1, gnt_wr, busy, abort, err_cnt};
        check_eq(tag, 32'(obs_v), 32'(exp_v));
        @(posedge clk);
        if (!rst) model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        ar0 = 0; wv0 = 0; ar1 = 0; wv1 = 0; arready = 0; wready = 0;
        rvalid = 0; rready = 0; bvalid = 0; bready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        model_reset();
        step("reset");
        step("reset");
        rst = 0;
    endtask

    int exp_seq[6] = '{0, 0, 1, 0, 0, 1};
    int seq[$];
    bit prev_busy;
    int mode;

    initial begin
        model_reset();
        #1;
        do_reset();

        // M0 read alone
        ar0 = 1; step("m0rd_t0");
        step("m0rd_t1");
        arready = 1; step("m0rd_t2");
        arready = 0; ar0 = 0; step("m0rd_t3");
        rvalid = 1; rready = 1; step("m0rd_t4");
        rvalid = 0; rready = 0; step("m0rd_t5");
        step("m0rd_t6");

        // Continuous contention with single-cycle transactions
        do_reset();
        ar0 = 1; ar1 = 1; arready = 1; rvalid = 1; rready = 1;
        prev_busy = 0;
        for (int i = 0; i < 40 && seq.size() < 6; i++) begin
            step("contend");
            if (busy && !prev_busy) seq.push_back(gnt_m1 ? 1 : 0);
            prev_busy = busy;
        end
        check_eq("contend_len", 32'(seq.size()), 32'd6);
        for (int i = 0; i < 6 && i < seq.size(); i++)
            check_eq("contend_seq", 32'(seq[i]), 32'(exp_seq[i]));
        clear_inputs();
        step("contend_end");
        step("contend_end");

        // M1 read and write together: read first, then the write
        do_reset();
        ar1 = 1; wv1 = 1; step("rdfirst_req");
        step("rdfirst_addr");
        arready = 1; step("rdfirst_ahs");
        arready = 0; ar1 = 0; rvalid = 1; rready = 1; step("rdfirst_rhs");
        clear_inputs(); wv1 = 1; step("wrnext_idle");
        step("wrnext_addr");
        wready = 1; step("wrnext_whs");
        wready = 0; wv1 = 0; bvalid = 1; bready = 1; step("wrnext_bhs");
        clear_inputs(); step("wrnext_done");

        // M1 write in flight while M0 requests
        do_reset();
        wv1 = 1; step("hold_req");
        ar0 = 1; step("hold_addr");
        wready = 1; step("hold_whs");
        wready = 0; wv1 = 0; step("hold_resp");
        step("hold_resp");
        bvalid = 1; bready = 1; step("hold_bhs");
        bvalid = 0; bready = 0; step("hold_idle");
        step("hold_m0gnt");
        check_eq("hold_gnt_m0", 32'(gnt_m0), 32'd1);
        clear_inputs(); arready = 1; step("hold_m0ahs");
        clear_inputs(); rvalid = 1; rready = 1; step("hold_m0rhs");
        clear_inputs(); step("hold_end");

        // Asynchronous reset while in RESP
        do_reset();
        ar0 = 1; step("arst_req");
        arready = 1; step("arst_ahs");
        clear_inputs(); step("arst_resp");
        rvalid = 1; rready = 1;
        rst = 1;
        #1;
        check_eq("arst_async", 32'({gnt_m0, gnt_m1, gnt_wr, busy, abort, err_cnt}), 32'd0);
        model_reset();
        step("arst_held");
        clear_inputs();
        rst = 0;
        ar0 = 1; ar1 = 1; step("arst_contend");
        step("arst_m0");
        check_eq("arst_m0_first", 32'({gnt_m0, gnt_m1}), 32'b10);
        clear_inputs(); arready = 1; step("arst_ahs2");
        clear_inputs(); rvalid = 1; rready = 1; step("arst_rhs2");
        clear_inputs(); step("arst_end");

`ifdef SB_ARB_TIMEOUT_EN
        // Hung reads: abort on every one, error count saturates
        do_reset();
        for (int r = 0; r < 300; r++) begin
            ar0 = 1; step("tmo_req");
            arready = 1; step("tmo_ahs");
            arready = 0; ar0 = 0;
            for (int c = 0; c < int'(TMO); c++) step("tmo_wait");
        end
        check_eq("tmo_err_sat", 32'(err_cnt), 32'd255);
`endif

        // Random traffic, alternating responsive and sluggish slave
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) mode = $urandom_range(0, 2);
            ar0 = ($urandom_range(0, 3) == 0);
            wv0 = ($urandom_range(0, 3) == 0);
            ar1 = ($urandom_range(0, 3) == 0);
            wv1 = ($urandom_range(0, 3) == 0);
            arready = ($urandom_range(0, 7) < ((mode == 0) ? 1 : 5));
            wready  = ($urandom_range(0, 7) < ((mode == 0) ? 1 : 5));
            rvalid  = ($urandom_range(0, 7) < ((mode == 1) ? 7 : 2));
            rready  = ($urandom_range(0, 7) < 6);
            bvalid  = ($urandom_range(0, 7) < ((mode == 1) ? 7 : 2));
            bready  = ($urandom_range(0, 7) < 6);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
